tmp_conv_sched: RTL



---
 rtl/tmp_conv_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tmp_conv_sched.sv
// Measurement scheduler for the temperature-sensor phase controller: sensor reset,
// settling window, then a ones-count of 2^OSR_LOG2 comparator decisions with a strobe watchdog.
module tmp_conv_sched #(
    parameter int unsigned SETTLE_CYC  = 31,
    parameter int unsigned OSR_LOG2    = 8,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                abort,
    input  logic                cmp,
    input  logic                cmp_strb,
    output logic                sens_rst,
    output logic                sens_en,
    output logic                busy,
    output logic                done,
    output logic [OSR_LOG2:0]   result,
    output logic                err
);

    localparam int unsigned DW = OSR_LOG2 + 1;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYC);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [DW-1:0] DEC_LAST    = DW'((1 << OSR_LOG2) - 1);
    localparam logic [DW-1:0] DEC_ONE     = DW'(1);
    localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYC - 2);
    localparam logic [WW-1:0] WD_ONE      = WW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SRST,
        SETTLE,
        CONVERT,
        FINISH
    } state_t;

    state_t          state, state_n;
    logic            srst_cnt, srst_cnt_n;
    logic [SW-1:0]   settle_cnt, settle_cnt_n;
    logic [DW-1:0]   dec_cnt, dec_cnt_n;
    logic [DW-1:0]   ones_cnt, ones_cnt_n;
    logic [WW-1:0]   wd_cnt, wd_cnt_n;
    logic [DW-1:0]   result_n;
    logic            done_n;
    logic            err_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            srst_cnt   <= 1'b0;
            settle_cnt <= '0;
            dec_cnt    <= '0;
            ones_cnt   <= '0;
            wd_cnt     <= '0;
            done       <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            srst_cnt   <= srst_cnt_n;
            settle_cnt <= settle_cnt_n;
            dec_cnt    <= dec_cnt_n;
            ones_cnt   <= ones_cnt_n;
            wd_cnt     <= wd_cnt_n;
            done       <= done_n;
            result     <= result_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        srst_cnt_n   = srst_cnt;
        settle_cnt_n = settle_cnt;
        dec_cnt_n    = dec_cnt;
        ones_cnt_n   = ones_cnt;
        wd_cnt_n     = wd_cnt;
        result_n     = result;
        done_n       = 1'b0;
        err_n        = err;
        sens_rst     = 1'b1;
        sens_en      = 1'b0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                if (req && !abort) begin
                    state_n      = SRST;
                    err_n        = 1'b0;
                    srst_cnt_n   = 1'b0;
                    settle_cnt_n = '0;
                    dec_cnt_n    = '0;
                    ones_cnt_n   = '0;
                    wd_cnt_n     = '0;
                end
            end

            SRST: begin
                sens_en = 1'b1;
                busy    = 1'b1;
                if (srst_cnt) begin
                    state_n  = SETTLE;
                    wd_cnt_n = '0;
                end else begin
                    srst_cnt_n = 1'b1;
                end
            end

            SETTLE, CONVERT: begin
                sens_rst = 1'b0;
                sens_en  = 1'b1;
                busy     = 1'b1;
                wd_cnt_n = cmp_strb ? '0 : wd_cnt + WD_ONE;

                if (state == SETTLE) begin
                    settle_cnt_n = settle_cnt + SETTLE_ONE;
                    if (settle_cnt == SETTLE_LAST) begin
                        state_n = CONVERT;
                    end
                end else if (cmp_strb) begin
                    dec_cnt_n  = dec_cnt + DEC_ONE;
                    ones_cnt_n = ones_cnt + DW'(cmp);
                    if (dec_cnt == DEC_LAST) begin
                        state_n  = FINISH;
                        result_n = ones_cnt_n;
                        done_n   = 1'b1;
                    end
                end

                // Fires one cycle early so done lands TIMEOUT_CYC cycles after the last strobe;
                // a strobe in the same cycle clears the watchdog instead.
                if (!cmp_strb && (wd_cnt == WD_LAST)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                end
            end

            FINISH: begin
                sens_rst = 1'b0;
                sens_en  = 1'b1;
                state_n  = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_n  = IDLE;
            done_n   = 1'b0;
            result_n = result;
            err_n    = err;
        end
    end

endmodule
